// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit that issues core requests on the ready /
// read_data_valid memory bus. Steers byte lanes for stores and loads, tracks
// in-order outstanding reads in a small FIFO and sign/zero-extends load data.
module mem_access_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_WIDTH       = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [TAG_WIDTH-1:0]      req_tag,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic [TAG_WIDTH-1:0]      rsp_tag,
  input  logic                      bus_ready,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [DATA_WIDTH-1:0]     bus_write_data,
  output logic [DATA_WIDTH/8-1:0]   bus_byte_enable,
  output logic                      bus_write_req,
  output logic                      bus_read_req,
  input  logic [DATA_WIDTH-1:0]     bus_read_data,
  input  logic                      bus_read_data_valid,
  output logic                      misaligned,
  output logic                      unexpected_data
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W    = $clog2(BE_WIDTH);
  localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [1:0]           size;
    logic                 uns;
    logic [OFF_W-1:0]     off;
    logic [TAG_WIDTH-1:0] tag;
  } rd_entry_t;

  rd_entry_t             fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic [OFF_W-1:0]      req_off;
  logic                  req_legal;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [BE_WIDTH-1:0]   be_base;
  logic [BE_WIDTH-1:0]   be_lanes;

  rd_entry_t             head;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic [DATA_WIDTH-1:0] top_bit;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [6:0]            nbits;

  assign req_off = req_addr[OFF_W-1:0];

  // Held in reset the unit accepts nothing; otherwise a slot opens when the
  // bus register is free or draining this cycle and the read FIFO has room.
  assign req_ready = reset_n
                   && ((!bus_write_req && !bus_read_req) || bus_ready)
                   && (fifo_count < CNT_W'(MAX_OUTSTANDING));
  assign accept = req_valid && req_ready;
  assign push   = accept && req_legal && !req_write;
  assign pop    = bus_read_data_valid && (fifo_count != '0);

  // Natural alignment check; double only exists on a 64-bit bus
  always_comb begin
    req_legal = 1'b1;
    case (req_size)
      2'd1:    req_legal = ~req_addr[0];
      2'd2:    req_legal = (req_addr[1:0] == 2'b00);
      2'd3:    req_legal = (DATA_WIDTH == 64) && (req_addr[2:0] == 3'b000);
      default: req_legal = 1'b1;
    endcase
  end

  // Byte-lane mask for the access, shifted to the addressed offset
  always_comb begin
    case (req_size)
      2'd0:    be_base = BE_WIDTH'(1);
      2'd1:    be_base = BE_WIDTH'(3);
      2'd2:    be_base = BE_WIDTH'(15);
      default: be_base = '1;
    endcase
    be_lanes = be_base << req_off;
  end

  // Load data extraction: right-justify, keep 8<<size bits, extend the top bit
  always_comb begin
    head      = fifo_mem[rd_ptr];
    shifted   = bus_read_data >> {head.off, 3'b000};
    nbits     = 7'd8 << head.size;
    keep_mask = ~({DATA_WIDTH{1'b1}} << nbits);
    top_bit   = keep_mask & ~(keep_mask >> 1);
    ext_data  = shifted & keep_mask;
    if (!head.uns && |(shifted & top_bit)) ext_data = ext_data | ~keep_mask;
  end

  // Single bus register shared by loads and stores, held until bus_ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_addr        <= '0;
      bus_write_data  <= '0;
      bus_byte_enable <= '0;
      bus_write_req   <= 1'b0;
      bus_read_req    <= 1'b0;
    end else if (accept && req_legal) begin
      bus_addr        <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      bus_write_data  <= req_wdata << {req_off, 3'b000};
      bus_byte_enable <= be_lanes;
      bus_write_req   <= req_write;
      bus_read_req    <= !req_write;
    end else if (bus_ready) begin
      bus_write_req   <= 1'b0;
      bus_read_req    <= 1'b0;
    end
  end

  // Read FIFO storage; entries are only meaningful below fifo_count
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{size: req_size, uns: req_unsigned, off: req_off, tag: req_tag};
  end

  // Read FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Registered load response and sticky error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_tag         <= '0;
      misaligned      <= 1'b0;
      unexpected_data <= 1'b0;
    end else begin
      rsp_valid <= pop;
      if (pop) begin
        rsp_data <= ext_data;
        rsp_tag  <= head.tag;
      end
      if (accept && !req_legal) misaligned <= 1'b1;
      if (bus_read_data_valid && (fifo_count == '0)) unexpected_data <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit instance checked every cycle against a
// queue-based behavioural model, plus a 64-bit instance with directed checks.
module tb_mem_access_unit;

  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_req_valid = 0, a_req_write = 0, a_req_unsigned = 0, a_bus_ready = 0, a_rdv = 0;
  logic [1:0]  a_req_size = 0;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0, a_rdata = 0;
  logic [4:0]  a_req_tag = 0;
  logic        a_req_ready, a_rsp_valid, a_bus_wr, a_bus_rd, a_mis, a_unx;
  logic [31:0] a_rsp_data, a_bus_addr, a_bus_wdata;
  logic [4:0]  a_rsp_tag;
  logic [3:0]  a_bus_be;

  // 64-bit instance
  logic        b_req_valid = 0, b_req_write = 0, b_req_unsigned = 0, b_bus_ready = 0, b_rdv = 0;
  logic [1:0]  b_req_size = 0;
  logic [31:0] b_req_addr = 0;
  logic [63:0] b_req_wdata = 0, b_rdata = 0;
  logic [4:0]  b_req_tag = 0;
  logic        b_req_ready, b_rsp_valid, b_bus_wr, b_bus_rd, b_mis, b_unx;
  logic [63:0] b_rsp_data, b_bus_wdata;
  logic [31:0] b_bus_addr;
  logic [4:0]  b_rsp_tag;
  logic [7:0]  b_bus_be;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(MAXO), .TAG_WIDTH(5)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_tag(a_req_tag),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_tag(a_rsp_tag),
    .bus_ready(a_bus_ready), .bus_addr(a_bus_addr), .bus_write_data(a_bus_wdata),
    .bus_byte_enable(a_bus_be), .bus_write_req(a_bus_wr), .bus_read_req(a_bus_rd),
    .bus_read_data(a_rdata), .bus_read_data_valid(a_rdv),
    .misaligned(a_mis), .unexpected_data(a_unx)
  );

  mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MAX_OUTSTANDING(MAXO), .TAG_WIDTH(5)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_tag(b_req_tag),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_tag(b_rsp_tag),
    .bus_ready(b_bus_ready), .bus_addr(b_bus_addr), .bus_write_data(b_bus_wdata),
    .bus_byte_enable(b_bus_be), .bus_write_req(b_bus_wr), .bus_read_req(b_bus_rd),
    .bus_read_data(b_rdata), .bus_read_data_valid(b_rdv),
    .misaligned(b_mis), .unexpected_data(b_unx)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the 32-bit instance ----------------
  typedef struct {
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
    logic [4:0] tag;
  } ent_t;

  ent_t        m_q[$];
  ent_t        m_e;
  logic        m_bv = 0, m_bw = 0, m_rv = 0, m_mis = 0, m_unx = 0, m_acc = 0;
  logic [31:0] m_addr = 0, m_wd = 0, m_rd = 0;
  logic [3:0]  m_be = 0;
  logic [4:0]  m_rt = 0;
  int          m_issued = 0;

  function automatic logic m_ready();
    return reset_n && (!m_bv || a_bus_ready) && (m_q.size() < MAXO);
  endfunction

  function automatic logic m_legal(input logic [1:0] sz, input logic [31:0] ad);
    return (sz != 2'd3) && ((ad % (32'd1 << sz)) == 0);
  endfunction

  function automatic logic [3:0] m_lanes(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] r = '0;
    for (int i = 0; i < (1 << sz); i++) begin
      int k = int'(off) + i;
      if (k < 4) r[k] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] rd, input logic [1:0] sz,
                                        input logic u, input logic [1:0] off);
    longint v;
    longint span;
    v = longint'(rd >> (8 * off));
    span = longint'(1) << (8 << sz);
    if (sz < 2) begin
      v = v % span;
      if (!u && v >= span / 2) v = v - span;
    end
    return v[31:0];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_bv = 0; m_bw = 0; m_rv = 0; m_mis = 0; m_unx = 0;
      m_addr = 0; m_wd = 0; m_rd = 0; m_be = 0; m_rt = 0; m_issued = 0;
    end else begin
      m_acc = a_req_valid && m_ready();
      if (m_bv && !m_bw && a_bus_ready) m_issued++;
      m_rv = 0;
      if (a_rdv) begin
        if (m_q.size() > 0) begin
          m_e = m_q.pop_front();
          m_rv = 1;
          m_rd = m_ext(a_rdata, m_e.size, m_e.uns, m_e.off);
          m_rt = m_e.tag;
          if (m_issued > 0) m_issued--;
        end else begin
          m_unx = 1;
        end
      end
      if (m_bv && a_bus_ready) m_bv = 0;
      if (m_acc) begin
        if (!m_legal(a_req_size, a_req_addr)) begin
          m_mis = 1;
        end else begin
          m_bv   = 1;
          m_bw   = a_req_write;
          m_addr = {a_req_addr[31:2], 2'b00};
          m_be   = m_lanes(a_req_size, a_req_addr[1:0]);
          m_wd   = a_req_wdata << (8 * a_req_addr[1:0]);
          if (!a_req_write)
            m_q.push_back('{size: a_req_size, uns: a_req_unsigned, off: a_req_addr[1:0], tag: a_req_tag});
        end
      end
    end
  end

  // Cycle-by-cycle comparison of the 32-bit instance against the model
  initial begin
    forever begin
      @(negedge clk);
      #4;
      chk("a_req_ready", a_req_ready, m_ready());
      chk("a_bus_write_req", a_bus_wr, m_bv && m_bw);
      chk("a_bus_read_req", a_bus_rd, m_bv && !m_bw);
      if (m_bv) begin
        chk("a_bus_addr", a_bus_addr, m_addr);
        chk("a_bus_byte_enable", a_bus_be, m_be);
        if (m_bw) chk("a_bus_write_data", a_bus_wdata, m_wd);
      end
      chk("a_rsp_valid", a_rsp_valid, m_rv);
      if (m_rv) begin
        chk("a_rsp_data", a_rsp_data, m_rd);
        chk("a_rsp_tag", a_rsp_tag, m_rt);
      end
      chk("a_misaligned", a_mis, m_mis);
      chk("a_unexpected_data", a_unx, m_unx);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic a_req(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] tg);
    a_req_valid = 1; a_req_write = w; a_req_size = sz; a_req_unsigned = u;
    a_req_addr = ad; a_req_wdata = wd; a_req_tag = tg;
  endtask

  task automatic b_req(input logic [1:0] sz, input logic [31:0] ad, input logic [4:0] tg);
    b_req_valid = 1; b_req_write = 0; b_req_size = sz; b_req_unsigned = 0;
    b_req_addr = ad; b_req_tag = tg;
  endtask

  task automatic lh_test(input logic u, input logic [31:0] exp);
    a_req(0, 2'd1, u, 32'h102, 32'h0, 5'd7);
    cyc();
    chk("lh_read_req", a_bus_rd, 1'b1);
    chk("lh_byte_enable", a_bus_be, 4'hC);
    chk("lh_addr", a_bus_addr, 32'h100);
    a_req_valid = 0;
    cyc();
    a_rdv = 1; a_rdata = 32'h80010000;
    cyc();
    a_rdv = 0;
    chk("lh_rsp_valid", a_rsp_valid, 1'b1);
    chk("lh_rsp_data", a_rsp_data, exp);
    chk("lh_rsp_tag", a_rsp_tag, 5'd7);
    cyc();
    chk("lh_rsp_pulse", a_rsp_valid, 1'b0);
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_a_req_ready", a_req_ready, 1'b0);
    chk("rst_a_strobes", {a_bus_wr, a_bus_rd, a_rsp_valid, a_mis, a_unx}, 5'b0);
    chk("rst_a_bus_addr", a_bus_addr, 32'h0);
    chk("rst_a_byte_enable", a_bus_be, 4'h0);
    chk("rst_a_rsp_data", a_rsp_data, 32'h0);
    chk("rst_b_outputs", {b_req_ready, b_bus_wr, b_bus_rd, b_rsp_valid, b_mis, b_unx}, 6'b0);
    reset_n = 1;
    a_bus_ready = 1;
    b_bus_ready = 1;

    // word store then byte store
    cyc();
    a_req(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 5'd0);
    cyc();
    chk("sw_write_req", a_bus_wr, 1'b1);
    chk("sw_addr", a_bus_addr, 32'h100);
    chk("sw_byte_enable", a_bus_be, 4'hF);
    chk("sw_write_data", a_bus_wdata, 32'hDEADBEEF);
    a_req_valid = 0;
    cyc();
    chk("sw_strobe_low", a_bus_wr, 1'b0);
    a_req(1, 2'd0, 0, 32'h103, 32'h000000A5, 5'd0);
    cyc();
    chk("sb_addr", a_bus_addr, 32'h100);
    chk("sb_byte_enable", a_bus_be, 4'h8);
    chk("sb_write_data", a_bus_wdata, 32'hA5000000);
    a_req_valid = 0;
    cyc();

    // halfword load signed / unsigned
    lh_test(1'b0, 32'hFFFF8001);
    lh_test(1'b1, 32'h00008001);

    // five back-to-back loads against a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      a_req(0, 2'd2, 0, 32'h200 + 32'(4 * i), 32'h0, 5'(i + 1));
      #1 chk("bb_req_ready", a_req_ready, (i < 4));
      cyc();
    end
    a_rdv = 1; a_rdata = 32'h11110000;
    #1 chk("bb_full_ready", a_req_ready, 1'b0);
    cyc();
    a_rdv = 0;
    #1 chk("bb_fifth_ready", a_req_ready, 1'b1);
    chk("bb_rsp1_valid", a_rsp_valid, 1'b1);
    chk("bb_rsp1_tag", a_rsp_tag, 5'd1);
    chk("bb_rsp1_data", a_rsp_data, 32'h11110000);
    cyc();
    a_req_valid = 0;
    for (int j = 1; j < 5; j++) begin
      a_rdv = 1; a_rdata = 32'h11110000 + 32'(j);
      cyc();
      chk("bb_rsp_valid", a_rsp_valid, 1'b1);
      chk("bb_rsp_tag", a_rsp_tag, 5'(j + 1));
      chk("bb_rsp_data", a_rsp_data, 32'h11110000 + 32'(j));
    end
    a_rdv = 0;
    cyc();

    // misaligned word load, then return data with nothing outstanding
    a_req(0, 2'd2, 0, 32'h102, 32'h0, 5'd3);
    cyc();
    a_req_valid = 0;
    chk("mis_set", a_mis, 1'b1);
    chk("mis_no_strobe", a_bus_rd, 1'b0);
    a_rdv = 1; a_rdata = 32'h00005555;
    cyc();
    a_rdv = 0;
    chk("unx_set", a_unx, 1'b1);
    chk("unx_no_rsp", a_rsp_valid, 1'b0);
    cyc();
    chk("mis_sticky", a_mis, 1'b1);
    chk("unx_sticky", a_unx, 1'b1);
    reset_n = 0;
    cyc();
    chk("rst_clears_flags", {a_mis, a_unx}, 2'b00);
    reset_n = 1;

    // randomized traffic, with one reset in the middle
    for (int c = 0; c < 4000; c++) begin
      cyc();
      if (c == 2000) reset_n = 0;
      if (c == 2002) reset_n = 1;
      a_bus_ready    = ($urandom_range(0, 9) < 7);
      a_req_valid    = ($urandom_range(0, 9) < 6);
      a_req_write    = 1'($urandom_range(0, 1));
      a_req_unsigned = 1'($urandom_range(0, 1));
      a_req_size     = ($urandom_range(0, 29) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a_req_addr     = $urandom;
      if ($urandom_range(0, 19) != 0) a_req_addr = a_req_addr & ~((32'd1 << a_req_size) - 32'd1);
      a_req_wdata    = $urandom;
      a_req_tag      = 5'($urandom);
      a_rdata        = $urandom;
      a_rdv          = (m_issued > 0) && ($urandom_range(0, 9) < 4);
    end
    a_req_valid = 0;
    a_rdv = 0;
    a_bus_ready = 1;
    cyc();

    // 64-bit instance: double pass-through and top-byte signed load
    b_req(2'd3, 32'h8, 5'd3);
    cyc();
    b_req_valid = 0;
    chk("ld_read_req", b_bus_rd, 1'b1);
    chk("ld_addr", b_bus_addr, 32'h8);
    chk("ld_byte_enable", b_bus_be, 8'hFF);
    cyc();
    b_rdv = 1; b_rdata = 64'h0123456789ABCDEF;
    cyc();
    b_rdv = 0;
    chk("ld_rsp_valid", b_rsp_valid, 1'b1);
    chk("ld_rsp_data", b_rsp_data, 64'h0123456789ABCDEF);
    chk("ld_rsp_tag", b_rsp_tag, 5'd3);
    b_req(2'd0, 32'hF, 5'd4);
    cyc();
    b_req_valid = 0;
    chk("lb64_byte_enable", b_bus_be, 8'h80);
    cyc();
    b_rdv = 1; b_rdata = 64'h8000000000000000;
    cyc();
    b_rdv = 0;
    chk("lb64_rsp_data", b_rsp_data, 64'hFFFFFFFFFFFFFF80);

    // reset with two reads outstanding
    b_req(2'd3, 32'h10, 5'd1);
    cyc();
    b_req(2'd2, 32'h14, 5'd2);
    cyc();
    b_req_valid = 0;
    cyc();
    reset_n = 0;
    #1;
    chk("rst64_flags", {b_req_ready, b_bus_wr, b_bus_rd, b_rsp_valid, b_mis, b_unx}, 6'b0);
    chk("rst64_bus_addr", b_bus_addr, 32'h0);
    chk("rst64_wdata", b_bus_wdata, 64'h0);
    chk("rst64_be", b_bus_be, 8'h0);
    chk("rst64_rsp", {b_rsp_data, 3'b000, b_rsp_tag}, 72'h0);
    cyc();
    reset_n = 1;
    cyc();
    b_rdv = 1; b_rdata = 64'h1;
    cyc();
    b_rdv = 0;
    chk("rst64_late_unexpected", b_unx, 1'b1);
    chk("rst64_late_no_rsp", b_rsp_valid, 1'b0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store unit that replaces the single fixed-width `sw` path in the multi-cycle core.
- Accepts load/store requests from the core and issues them on the core's existing ready/read_data_valid memory bus.
- Supports byte, half, word and (when DATA_WIDTH=64) double accesses, with lane steering and sign/zero extension.
- Tracks up to MAX_OUTSTANDING in-order reads, so loads can be pipelined.

Parameters:
DATA_WIDTH, 32, bus data width; legal values 32 or 64; BE_WIDTH=DATA_WIDTH/8.
ADDR_WIDTH, 32, byte address width.
MAX_OUTSTANDING, 4, maximum reads issued but not yet returned; power of two, ≥1.
TAG_WIDTH, 5, width of the opaque tag returned with load data (typically rd).

Ports:
clk  in  1  clock; all logic on posedge.
reset_n  in  1  asynchronous active-low reset.
req_valid  in  1  core request valid.
req_ready  out  1  unit accepts the request this cycle.
req_write  in  1  1=store, 0=load.
req_size  in  2  0=byte 1=half 2=word 3=double.
req_unsigned  in  1  load zero-extends when 1.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  DATA_WIDTH  store data, right-justified.
req_tag  in  TAG_WIDTH  tag for load response.
rsp_valid  out  1  load data valid (one-cycle pulse, no backpressure).
rsp_data  out  DATA_WIDTH  extended load data.
rsp_tag  out  TAG_WIDTH  tag of the completed load.
bus_ready  in  1  bus accepts the asserted request this cycle.
bus_addr  out  ADDR_WIDTH  aligned address; low log2(BE_WIDTH) bits are 0.
bus_write_data  out  DATA_WIDTH  store data shifted to its lanes.
bus_byte_enable  out  BE_WIDTH  active lanes.
bus_write_req  out  1  write request.
bus_read_req  out  1  read request.
bus_read_data  in  DATA_WIDTH  read return data.
bus_read_data_valid  in  1  read return strobe; returns are in issue order.
misaligned  out  1  sticky: a misaligned or illegal-size request was dropped.
unexpected_data  out  1  sticky: read data arrived while no read was outstanding.

Behaviour:
- Reset: all outputs are 0; the read FIFO is emptied and the bus register cleared. Reset mid-operation abandons all outstanding reads, and later returns raise unexpected_data.
- Handshake: a request is accepted when req_valid && req_ready.
  - req_ready = (!bus_write_req && !bus_read_req || bus_ready) && (fifo_count < MAX_OUTSTANDING).
  - req_ready does not depend on req_write.
- Legality check:
  - A request is legal only if addr mod (1<<size) == 0.
  - size 3 is illegal when DATA_WIDTH=32.
  - An illegal request is accepted, sets misaligned, and produces no bus access or response.
- Issue (accept in cycle t):
  - bus_addr, bus_byte_enable, bus_write_data and the req strobe are registered and valid from t+1.
  - They are held stable until a cycle with bus_ready=1.
  - The strobe deasserts in the following cycle, unless a new request is accepted in the same cycle (back-to-back issue, zero bubbles).
- Lane steering:
  - off = addr[log2(BE_WIDTH)-1:0].
  - byte_enable = ((1<<(1<<size))-1) << off.
  - write_data = req_wdata << (8*off).
  - Loads drive the same byte_enable.
- Read FIFO:
  - Each accepted legal load pushes {size, unsigned, off, tag} at acceptance.
  - bus_read_data_valid pops the head.
  - Simultaneous push and pop leaves the count unchanged.
  - The count saturates at MAX_OUTSTANDING via req_ready; pointers wrap modulo MAX_OUTSTANDING.
- Response:
  - Registered; rsp_valid is asserted in the cycle after bus_read_data_valid.
  - rsp_data = bus_read_data >> (8*off), truncated to 8<<size bits, then sign-extended (unless unsigned) to DATA_WIDTH; size 3 passes through.
  - rsp_tag = head tag.
- Data with an empty FIFO sets unexpected_data; no rsp_valid is produced.
- Stores produce no response. Stores and loads share the single bus register and therefore issue in acceptance order.

Test Plan:
- DATA_WIDTH=32, store sw addr 0x100 data 0xDEADBEEF, bus_ready=1 -> next cycle bus_write_req=1, bus_addr=0x100, byte_enable=4'hF, write_data=0xDEADBEEF; strobe low the cycle after.
- Store sb addr 0x103 data 0x000000A5 -> bus_addr=0x100, byte_enable=4'h8, write_data=0xA5000000.
- Load lh signed addr 0x102 tag 7, memory returns 0x80010000 -> rsp_valid one cycle after return, rsp_data=0xFFFF8001, rsp_tag=7; the same load unsigned gives 0x00008001.
- MAX_OUTSTANDING=4: issue 5 back-to-back loads with no returns -> req_ready low after the 4th accept; return one datum -> 5th accepted the following cycle; responses and tags come back in order.
- Load lw addr 0x102 -> misaligned=1 sticky, no bus strobe; then bus_read_data_valid with an empty FIFO -> unexpected_data=1, no rsp_valid.
- DATA_WIDTH=64, ld addr 0x8, return 0x0123456789ABCDEF -> rsp_data unchanged; assert reset_n low with 2 reads outstanding -> all outputs 0 and the FIFO empty.
